// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NREG_DEFAULT = 32;

  // Address width for a register count; at least one bit so NREG=2 still indexes.
  function automatic int unsigned addr_width(input int unsigned nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, write, issue and flush bundle for the register file with scoreboard.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned NREG = NREG_DEFAULT,
  parameter int unsigned NRP  = 2,
  parameter int unsigned NWP  = 2
);

  localparam int unsigned AW = addr_width(NREG);

  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*XLEN-1:0] rs_data;
  logic [NRP-1:0]      rs_busy;
  logic [NWP-1:0]      wr_en;
  logic [NWP*AW-1:0]   wr_addr;
  logic [NWP*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic                flush;
  logic [AW:0]         busy_cnt;

  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
    input  rs_data, rs_busy, busy_cnt
  );

  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
    output rs_data, rs_busy, busy_cnt
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write flags per register plus a registered count of pending registers.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEFAULT,
  parameter int unsigned NWP  = 2,
  parameter int unsigned AW   = addr_width(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWP-1:0]    wr_en,
  input  logic [NWP*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  input  logic              flush,
  output logic [NREG-1:0]   pending,
  output logic [AW:0]       busy_cnt
);

  logic [NREG-1:0] pending_q, pending_d;
  logic [AW:0]     cnt_q, cnt_d;

  // Writeback clears, a new issue sets (and wins over writeback), flush clears all.
  always_comb begin
    pending_d = pending_q;
    for (int w = 0; w < NWP; w++) begin
      if (wr_en[w]) pending_d[wr_addr[w*AW +: AW]] = 1'b0;
    end
    if (iss_en) pending_d[iss_rd] = 1'b1;
    if (flush) pending_d = '0;
    pending_d[0] = 1'b0;
  end

  // Count from next-state flags so the registered count never lags the flags.
  always_comb begin
    cnt_d = '0;
    for (int i = 1; i < NREG; i++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, pending_d[i]};
    end
  end

  // Flag and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending  = pending_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with optional write-to-read bypass and a pending-write scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREG   = NREG_DEFAULT,
  parameter int unsigned NRP    = 2,
  parameter int unsigned NWP    = 2,
  parameter int unsigned BYPASS = 1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned AW = addr_width(NREG);

  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           pending;
  logic [NRP*XLEN-1:0]       rdata;
  logic [NRP-1:0]            rbusy;

  // Commit writes in port order so the highest-indexed port wins a collision; x0 is never written.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NWP; w++) begin
      if (bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] != '0)) begin
        regs_d[bus.wr_addr[w*AW +: AW]] = bus.wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // Data array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  // Combinational reads with optional forwarding; outputs forced to 0 while in reset.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int p = 0; p < NRP; p++) begin
      rdata[p*XLEN +: XLEN] = regs_q[bus.rs_addr[p*AW +: AW]];
      rbusy[p]              = pending[bus.rs_addr[p*AW +: AW]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWP; w++) begin
          if (bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] == bus.rs_addr[p*AW +: AW]) &&
              (bus.wr_addr[w*AW +: AW] != '0)) begin
            rdata[p*XLEN +: XLEN] = bus.wr_data[w*XLEN +: XLEN];
            rbusy[p]              = 1'b0;
          end
        end
      end
    end
    if (rst) begin
      rdata = '0;
      rbusy = '0;
    end
  end

  assign bus.rs_data = rdata;
  assign bus.rs_busy = rbusy;

  rf_scoreboard #(
    .NREG (NREG),
    .NWP  (NWP),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_en   (bus.iss_en),
    .iss_rd   (bus.iss_rd),
    .flush    (bus.flush),
    .pending  (pending),
    .busy_cnt (bus.busy_cnt)
  );

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=2); AW = log2(NREG).
REQ-003 SHALL have parameter NRP, default 2, number of read ports.
REQ-004 SHALL have parameter NWP, default 2, number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable.
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port rs_addr, input, NRP*AW, read addresses (port p at [p*AW +: AW]).
REQ-009 SHALL have port rs_data, output, NRP*XLEN, read data per port.
REQ-010 SHALL have port rs_busy, output, NRP, pending-write flag per read port.
REQ-011 SHALL have port wr_en, input, NWP, write enables.
REQ-012 SHALL have port wr_addr, input, NWP*AW, write addresses.
REQ-013 SHALL have port wr_data, input, NWP*XLEN, write data.
REQ-014 SHALL have port iss_en, input, 1, issue strobe that marks iss_rd pending.
REQ-015 SHALL have port iss_rd, input, AW, destination register of the issuing instruction.
REQ-016 SHALL have port flush, input, 1, clears all pending flags.
REQ-017 SHALL have port busy_cnt, output, AW+1, number of registers currently pending.

Function
REQ-018 SHALL commit write port w on the rising edge when wr_en[w]=1 and wr_addr[w]!=0.
REQ-019 SHALL make register 0 read as 0 and never pending; writes and issues to address 0 have no effect.
REQ-020 SHALL resolve same-cycle writes to one address so that the highest-indexed enabled port wins.
REQ-021 SHALL make reads combinational; with BYPASS=1, a read matching an enabled write in the same cycle returns that write's data (highest port wins); with BYPASS=0, it returns the stored value.
REQ-022 SHALL set pending[iss_rd] on the edge when iss_en=1 and iss_rd!=0.
REQ-023 SHALL clear pending[a] on the edge when any enabled write targets a.
REQ-024 SHALL let set win when issue and writeback target the same register in one cycle (new producer).
REQ-025 SHALL make flush clear every pending flag on the edge, overriding a same-cycle issue; register data is unaffected and same-cycle writes still commit.
REQ-026 SHALL drive rs_busy[p] = pending[rs_addr[p]], masked to 0 when BYPASS=1 and an enabled write to that address exists in the same cycle.
REQ-027 SHALL keep busy_cnt equal to the popcount of the pending flags, registered, with zero-cycle lag relative to the flags.
REQ-028 SHALL hold busy_cnt at most NREG-1 without wrap.

Reset
REQ-029 SHALL, on rst assertion and without waiting for a clock edge, clear all registers to 0, all pending flags to 0, and busy_cnt to 0.
REQ-030 SHALL give rs_data and rs_busy the value 0 during reset; an issue or write coincident with reset is discarded.
REQ-031 SHALL treat release of rst as synchronous to the source; the first edge after release is a normal cycle.

Structure
REQ-032 SHALL place the default XLEN/NREG constants and the AW derivation function in shared package regfile_pkg.
REQ-033 SHALL implement the scoreboard (pending flags and busy_cnt) as sub-module rf_scoreboard; the data array and bypass muxing stay in the top level.

Verification
REQ-034 SHALL check: reset, then read all addresses -> rs_data=0, rs_busy=0, busy_cnt=0.
REQ-035 SHALL check: write port0 x5=0xDEADBEEF and port1 x5=0x12345678 in the same cycle -> the next read of x5 returns 0x12345678.
REQ-036 SHALL check, with BYPASS=1: write x3=0xA5A5A5A5 while reading x3 in the same cycle -> rs_data=0xA5A5A5A5 in that cycle; with BYPASS=0 -> the old value.
REQ-037 SHALL check: issue x7 then x9 -> busy_cnt=2; writeback x7 together with issue x7 -> x7 still busy, busy_cnt=2.
REQ-038 SHALL check: issue x0 or write x0=0xFFFFFFFF -> x0 reads 0, not busy, busy_cnt unchanged.
REQ-039 SHALL check: 4 registers pending, flush together with issue x2 -> busy_cnt=0; asynchronous rst mid-burst -> all state 0 immediately.
